// File: rtl/snapshot_sequencer.sv
// Sequences one event snapshot: ID header, timestamp header, GPR words, stack words.
// Define SNAPSHOT_SEQ_DROPCNT_EN to add an 8-bit dropped-event counter emitted as a trailer word.
module snapshot_sequencer #(
  parameter int EV_ID_WIDTH     = 5,
  parameter int TIMESTAMP_WIDTH = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ev_valid,
  input  logic [EV_ID_WIDTH-1:0]     ev_id,
  input  logic [TIMESTAMP_WIDTH-1:0] ev_time,
  output logic                       ev_ready,
  input  logic [DATA_WIDTH:0]        gpr_data,
  input  logic [2:0]                 gpr_type,
  input  logic                       gpr_valid,
  output logic                       gpr_rdy,
  input  logic [DATA_WIDTH:0]        stack_data,
  input  logic [2:0]                 stack_type,
  input  logic                       stack_valid,
  output logic                       stack_rdy,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [2:0]                 out_type,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);

`ifdef SNAPSHOT_SEQ_DROPCNT_EN
  typedef enum logic [2:0] {IDLE, HDR_ID, HDR_TIME, GPR, STACK, TRAIL} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR_ID, HDR_TIME, GPR, STACK} state_t;
`endif

  state_t                       state_q, state_d;
  logic                         init_p0;
  logic [EV_ID_WIDTH-1:0]       ev_id_p0;
  logic [TIMESTAMP_WIDTH-1:0]   ev_time_p0;

  logic                         can_load, fin, last_pend;
  logic                         load;
  logic [DATA_WIDTH-1:0]        ld_data;
  logic [2:0]                   ld_type;
  logic                         ld_last;

  // The output register can take a new word when empty or draining this cycle.
  assign can_load  = !out_valid || out_ready;
  assign last_pend = out_valid && out_last;
  assign fin       = last_pend && out_ready;

`ifdef SNAPSHOT_SEQ_DROPCNT_EN
  logic [7:0] drop_cnt;
  logic       drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign drop = ev_valid && !ev_ready;
`endif

  // State names the next word to be loaded; terminal states wait for the final handshake.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    ld_data   = '0;
    ld_type   = 3'b000;
    ld_last   = 1'b0;
    ev_ready  = 1'b0;
    gpr_rdy   = 1'b0;
    stack_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        ev_ready = init_p0;
        if (ev_valid && init_p0) state_d = HDR_ID;
      end
      HDR_ID: begin
        if (can_load) begin
          load    = 1'b1;
          ld_data = DATA_WIDTH'(ev_id_p0);
          ld_type = 3'b000;
          state_d = HDR_TIME;
        end
      end
      HDR_TIME: begin
        if (can_load) begin
          load    = 1'b1;
          ld_data = DATA_WIDTH'(ev_time_p0);
          ld_type = 3'b001;
          state_d = GPR;
        end
      end
      GPR: begin
        gpr_rdy = can_load;
        if (gpr_valid && can_load) begin
          load    = 1'b1;
          ld_data = gpr_data[DATA_WIDTH-1:0];
          ld_type = gpr_type;
          if (gpr_data[DATA_WIDTH]) state_d = STACK;
        end
      end
`ifdef SNAPSHOT_SEQ_DROPCNT_EN
      STACK: begin
        stack_rdy = can_load;
        if (stack_valid && can_load) begin
          load    = 1'b1;
          ld_data = stack_data[DATA_WIDTH-1:0];
          ld_type = stack_type;
          if (stack_data[DATA_WIDTH]) state_d = TRAIL;
        end
      end
      TRAIL: begin
        if (fin) begin
          state_d = IDLE;
        end else if (!last_pend && can_load) begin
          load    = 1'b1;
          ld_data = DATA_WIDTH'(drop_cnt);
          ld_type = 3'b111;
          ld_last = 1'b1;
        end
      end
`else
      STACK: begin
        // Once the last stack word sits in the output register, hold off further words.
        stack_rdy = can_load && !last_pend;
        if (fin) begin
          state_d = IDLE;
        end else if (stack_valid && stack_rdy) begin
          load    = 1'b1;
          ld_data = stack_data[DATA_WIDTH-1:0];
          ld_type = stack_type;
          ld_last = stack_data[DATA_WIDTH];
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_p0 <= 1'b0;
    end else begin
      state_q <= state_d;
      init_p0 <= 1'b1;
    end
  end

  // Event capture stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_id_p0   <= '0;
      ev_time_p0 <= '0;
    end else if (ev_valid && ev_ready) begin
      ev_id_p0   <= ev_id;
      ev_time_p0 <= ev_time;
    end
  end

  // Output stage: holds its word until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_type  <= 3'b000;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ld_data;
      out_type  <= ld_type;
      out_last  <= ld_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef SNAPSHOT_SEQ_DROPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (state_q == TRAIL && fin) begin
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_snapshot_sequencer.sv
// Directed bench for snapshot_sequencer: a vector table for the basic snapshot plus
// hand-written multi-cycle sequences (stalls, drops, back-to-back, reset mid-snapshot).
module tb_snapshot_sequencer;
`ifdef SNAPSHOT_SEQ_DROPCNT_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ev_valid;
  logic [4:0]  ev_id;
  logic [31:0] ev_time;
  logic        ev_ready;
  logic [32:0] gpr_data;
  logic [2:0]  gpr_type;
  logic        gpr_valid;
  logic        gpr_rdy;
  logic [32:0] stack_data;
  logic [2:0]  stack_type;
  logic        stack_valid;
  logic        stack_rdy;
  logic [31:0] out_data;
  logic [2:0]  out_type;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  snapshot_sequencer #(.EV_ID_WIDTH(5), .TIMESTAMP_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_valid), .ev_id(ev_id), .ev_time(ev_time), .ev_ready(ev_ready),
    .gpr_data(gpr_data), .gpr_type(gpr_type), .gpr_valid(gpr_valid), .gpr_rdy(gpr_rdy),
    .stack_data(stack_data), .stack_type(stack_type), .stack_valid(stack_valid), .stack_rdy(stack_rdy),
    .out_data(out_data), .out_type(out_type), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev_v;
    logic        gv;
    logic [32:0] gd;
    logic [2:0]  gt;
    logic        sv;
    logic [32:0] sd;
    logic [2:0]  st;
    logic [2:0]  rdys;
    logic        ov;
    logic [31:0] od;
    logic [2:0]  ot;
    logic        ol;
  } vec_t;

  typedef struct packed {
    logic [2:0]  t;
    logic        l;
    logic [31:0] d;
  } word_t;

  vec_t tbl[9];

  function automatic vec_t mk(input logic ev_v, input logic gv, input logic [32:0] gd,
                              input logic [2:0] gt, input logic sv, input logic [32:0] sd,
                              input logic [2:0] st, input logic [2:0] rdys, input logic ov,
                              input logic [31:0] od, input logic [2:0] ot, input logic ol);
    vec_t v;
    v.ev_v = ev_v; v.gv = gv; v.gd = gd; v.gt = gt; v.sv = sv; v.sd = sd; v.st = st;
    v.rdys = rdys; v.ov = ov; v.od = od; v.ot = ot; v.ol = ol;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ev_valid = 1'b0; ev_id = '0; ev_time = '0;
    gpr_valid = 1'b0; gpr_data = '0; gpr_type = '0;
    stack_valid = 1'b0; stack_data = '0; stack_type = '0;
    out_ready = 1'b1;
  endtask

  // Runs one snapshot from IDLE; called at 1 time unit after a rising edge.
  task automatic run_snap(input logic [4:0] id, input logic [31:0] tm, input int ngpr,
                          input int nstk, input int rmode, input int ndrop, input int carry,
                          input bit b2b, input int abort_at);
    word_t exp_w[$];
    word_t w;
    int gi = 0, si = 0, oi = 0, first_v = -1, cyc = 0, tcnt;
    bit done = 1'b0, aborted = 1'b0, prev_stall = 1'b0;
    word_t prev_w;
    w = '{3'b000, 1'b0, {27'd0, id}};   exp_w.push_back(w);
    w = '{3'b001, 1'b0, tm};            exp_w.push_back(w);
    for (int i = 0; i < ngpr; i++) begin
      w = '{3'b010, 1'b0, 32'h1000_0000 + i}; exp_w.push_back(w);
    end
    for (int i = 0; i < nstk; i++) begin
      w = '{3'b101, (!DC && i == nstk - 1), 32'h2000_0000 + i}; exp_w.push_back(w);
    end
    tcnt = (ndrop + carry > 255) ? 255 : ndrop + carry;
    if (DC) begin
      w = '{3'b111, 1'b1, tcnt}; exp_w.push_back(w);
    end
    while (!done && !aborted && cyc < 400) begin
      ev_valid = (cyc == 0) || (cyc >= 2 && cyc < 2 + ndrop);
      ev_id = id; ev_time = tm;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = (cyc >= 300);
      endcase
      gpr_valid = (gi < ngpr);
      gpr_data = {(gi == ngpr - 1), 32'h1000_0000 + gi}; gpr_type = 3'b010;
      stack_valid = (si < nstk);
      stack_data = {(si == nstk - 1), 32'h2000_0000 + si}; stack_type = 3'b101;
      #1;
      if (cyc == 0) check("ev_accept", ev_ready, 1'b1);
      check("rdy_excl", gpr_rdy && stack_rdy, 1'b0);
      if (stack_valid && gi < ngpr) check("stk_wait_gpr", stack_rdy, 1'b0);
      if (prev_stall) check("stall_hold", {out_valid, out_type, out_last, out_data}, {1'b1, prev_w});
      if (out_valid && first_v < 0) begin
        first_v = cyc;
        check("hdr_latency", cyc, 2);
      end
      if (out_valid && out_ready) begin
        if (oi < exp_w.size()) check($sformatf("word%0d", oi), {out_type, out_last, out_data}, exp_w[oi]);
        else check("extra_word", 1'b1, 1'b0);
        oi++;
        if (oi == exp_w.size()) done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_w = '{out_type, out_last, out_data};
      if (gpr_valid && gpr_rdy) gi++;
      if (stack_valid && stack_rdy) si++;
      if (cyc == abort_at) begin
        aborted = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {out_valid, out_last, out_type, out_data, ev_ready, gpr_rdy, stack_rdy}, 0);
        idle_inputs();
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_ev_ready_low", ev_ready, 1'b0);
      end
      if (done && b2b) ev_valid = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    gpr_valid = 1'b0; stack_valid = 1'b0;
    if (aborted) begin
      check("rst_ev_ready_rise", ev_ready, 1'b1);
    end else if (!done) begin
      check("snapshot_timeout", 1'b0, 1'b1);
    end else if (!b2b) begin
      ev_valid = 1'b0;
      #1;
      check("back_to_idle", {ev_ready, out_valid, out_last}, 3'b100);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {out_valid, out_last, out_type, out_data}, 0);
    check("reset_readies", {ev_ready, gpr_rdy, stack_rdy}, 3'b000);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("ev_ready_before_edge", ev_ready, 1'b0);
    @(posedge clk); #1;
    check("ev_ready_after_edge", ev_ready, 1'b1);

    tbl[0] = mk(1, 0, 33'h0, 3'd0, 0, 33'h0, 3'd0, 3'b100, 0, 32'h0, 3'd0, 0);
    tbl[1] = mk(0, 0, 33'h0, 3'd0, 0, 33'h0, 3'd0, 3'b000, 0, 32'h0, 3'd0, 0);
    tbl[2] = mk(0, 1, {1'b0, 32'hAAAA_0000}, 3'd2, 0, 33'h0, 3'd0, 3'b000, 1, 32'h0000_000A, 3'd0, 0);
    tbl[3] = mk(0, 1, {1'b0, 32'hAAAA_0000}, 3'd2, 0, 33'h0, 3'd0, 3'b010, 1, 32'h0000_1234, 3'd1, 0);
    tbl[4] = mk(0, 1, {1'b1, 32'hAAAA_0001}, 3'd3, 0, 33'h0, 3'd0, 3'b010, 1, 32'hAAAA_0000, 3'd2, 0);
    tbl[5] = mk(0, 0, 33'h0, 3'd0, 1, {1'b1, 32'h5555_0000}, 3'd4, 3'b001, 1, 32'hAAAA_0001, 3'd3, 0);
    tbl[6] = mk(0, 0, 33'h0, 3'd0, 0, 33'h0, 3'd0, 3'b000, 1, 32'h5555_0000, 3'd4, !DC);
    tbl[7] = DC ? mk(0, 0, 33'h0, 3'd0, 0, 33'h0, 3'd0, 3'b000, 1, 32'h0, 3'd7, 1)
                : mk(0, 0, 33'h0, 3'd0, 0, 33'h0, 3'd0, 3'b100, 0, 32'h0, 3'd0, 0);
    tbl[8] = mk(0, 0, 33'h0, 3'd0, 0, 33'h0, 3'd0, 3'b100, 0, 32'h0, 3'd0, 0);

    for (int r = 0; r < 9; r++) begin
      ev_valid = tbl[r].ev_v; ev_id = 5'h0A; ev_time = 32'h0000_1234;
      gpr_valid = tbl[r].gv; gpr_data = tbl[r].gd; gpr_type = tbl[r].gt;
      stack_valid = tbl[r].sv; stack_data = tbl[r].sd; stack_type = tbl[r].st;
      out_ready = 1'b1;
      #1;
      check($sformatf("tbl%0d_rdys", r), {ev_ready, gpr_rdy, stack_rdy}, tbl[r].rdys);
      check($sformatf("tbl%0d_vld_last", r), {out_valid, out_last}, {tbl[r].ov, tbl[r].ol});
      if (tbl[r].ov) check($sformatf("tbl%0d_word", r), {out_type, out_data}, {tbl[r].ot, tbl[r].od});
      @(posedge clk); #1;
    end
    idle_inputs();

    run_snap(5'h11, 32'hCAFE_0001, 3, 2, 1, 3, 0, 1'b0, -1);
    run_snap(5'h1F, 32'hFFFF_FFFF, 2, 1, 0, 0, 0, 1'b1, -1);
    run_snap(5'h13, 32'h0000_0013, 1, 2, 0, 0, 1, 1'b0, -1);
    run_snap(5'h16, 32'h0000_0016, 1, 1, 2, 260, 0, 1'b0, -1);
    run_snap(5'h14, 32'h0000_0014, 4, 1, 0, 0, 0, 1'b0, 5);
    run_snap(5'h15, 32'h0000_0015, 2, 1, 1, 1, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
